// File: rtl/twiddle_pkg.sv
// Shared types and constants for the IFFT twiddle fetch path.
//   TW_ADDR_W / TW_DATA_W : default ROM address and twiddle word widths
//   tw_state_t            : sequencer states
//   tw_pair_t             : one buffered twiddle pair plus its end-of-request flag
package twiddle_pkg;

  localparam int TW_ADDR_W = 5;
  localparam int TW_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } tw_state_t;

  typedef struct packed {
    logic [TW_DATA_W-1:0] re;
    logic [TW_DATA_W-1:0] im;
    logic                 last;
  } tw_pair_t;

endpackage

// File: rtl/twiddle_fetch_ctrl_if.sv
// Twiddle pair stream from the fetch sequencer to the butterfly unit.
//   tw_re / tw_im : twiddle pair, stable while tw_valid && !tw_ready
//   tw_valid      : pair available
//   tw_ready      : consumer accepts
//   tw_last       : final pair of the current request
// master = producer (sequencer), slave = consumer (butterfly).
interface twiddle_fetch_ctrl_if
  import twiddle_pkg::*;
#(
  parameter int DATA_W = TW_DATA_W
);

  logic [DATA_W-1:0] tw_re;
  logic [DATA_W-1:0] tw_im;
  logic              tw_valid;
  logic              tw_ready;
  logic              tw_last;

  modport master (output tw_re, output tw_im, output tw_valid, output tw_last,
                  input  tw_ready);

  modport slave  (input  tw_re, input  tw_im, input  tw_valid, input  tw_last,
                  output tw_ready);

endinterface

// File: rtl/twiddle_skid_buf.sv
// Two-entry FIFO holding twiddle pairs between the ROM read port and the
// output stream. The head entry drives the stream directly.
//   push / din : write one pair (never asserted while full)
//   pop        : remove the head pair (only asserted while non-empty)
//   flush      : empty the FIFO on the next edge; takes priority over push/pop
//   head       : oldest stored pair
//   occ        : number of stored pairs, 0..2
module twiddle_skid_buf
  import twiddle_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  tw_pair_t   din,
  input  logic       pop,
  input  logic       flush,
  output tw_pair_t   head,
  output logic [1:0] occ
);

  tw_pair_t mem [2];
  logic     wr_ptr;
  logic     rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset because the head entry drives the stream
      // outputs directly and those must come out of reset as zero.
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/twiddle_fetch_ctrl.sv
// Read-side sequencer for the real/imaginary twiddle ROM pair. Walks a
// wrapping address range, absorbs the one-cycle registered ROM latency and
// delivers pairs over a valid/ready stream with full backpressure.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start/base/count    : request pulse with first address and pair count
//   abort               : synchronous flush back to IDLE (no done pulse)
//   rom_addr            : shared address to both ROMs
//   rom_re/im_data      : ROM outputs, valid the cycle after the address
//   tw (master)         : twiddle pair stream to the butterfly unit
//   busy                : request in progress
//   done                : one-cycle pulse after the final handshake
// DATA_W must equal TW_DATA_W because the buffer stores tw_pair_t entries.
module twiddle_fetch_ctrl
  import twiddle_pkg::*;
#(
  parameter int ADDR_W = TW_ADDR_W,
  parameter int DATA_W = TW_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base,
  input  logic [ADDR_W:0]      count,
  input  logic                 abort,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [DATA_W-1:0]    rom_re_data,
  input  logic [DATA_W-1:0]    rom_im_data,
  twiddle_fetch_ctrl_if.master tw,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  tw_state_t       state_q, state_d;
  logic [ADDR_W:0] cnt_q;            // pairs requested
  logic [ADDR_W:0] idx_q;            // index of the address currently on rom_addr
  logic            inflight_q;       // ROM data for last cycle's address arrives now
  logic            inflight_last_q;  // ...and it is the final pair
  logic            done_d;
  logic            issue;
  logic            issue_last;
  logic            pop;
  logic [1:0]      occ;
  logic [2:0]      load;
  tw_pair_t        head;
  tw_pair_t        din;

  assign pop        = tw.tw_valid & tw.tw_ready;
  assign issue_last = (idx_q == cnt_q - CNT_ONE);
  // Pairs already committed to the buffer: stored ones plus the one in flight.
  assign load       = {1'b0, occ} + {2'b00, inflight_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses <= so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    state_d = state_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (count != '0) state_d = FETCH;
            else             done_d  = 1'b1;
          end
        end
        FETCH: if (issue && issue_last) state_d = DRAIN;
        DRAIN: begin
          // The last-flagged pair is always the final one pushed, so its
          // handshake also means the buffer is empty.
          if (pop && head.last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: issue only while the buffer can still absorb the result,
  // counting a pair leaving this cycle as freed space.
  always_comb begin
    busy  = (state_q != IDLE);
    issue = (state_q == FETCH) && (load < (3'd2 + {2'b00, pop}));
  end

  // Address counter, issue counter and inflight tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr        <= '0;
      cnt_q           <= '0;
      idx_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done            <= 1'b0;
    end else begin
      done            <= done_d;
      inflight_q      <= issue & ~abort;
      inflight_last_q <= issue & issue_last & ~abort;
      if (!abort) begin
        if (state_q == IDLE && start) begin
          rom_addr <= base;
          cnt_q    <= count;
          idx_q    <= '0;
        end else if (issue) begin
          rom_addr <= rom_addr + ADDR_ONE;  // wraps modulo 2^ADDR_W
          idx_q    <= idx_q + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    din      = '0;
    din.re   = rom_re_data;
    din.im   = rom_im_data;
    din.last = inflight_last_q;
  end

  twiddle_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .din   (din),
    .pop   (pop),
    .flush (abort),
    .head  (head),
    .occ   (occ)
  );

  assign tw.tw_re    = head.re;
  assign tw.tw_im    = head.im;
  assign tw.tw_last  = head.last;
  assign tw.tw_valid = (occ != 2'd0);

endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Directed testbench for twiddle_fetch_ctrl with registered ROM models.
module tb_twiddle_fetch_ctrl;
  import twiddle_pkg::*;

  localparam int AW = TW_ADDR_W;
  localparam int DW = TW_DATA_W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic          abort;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_re_data;
  logic [DW-1:0] rom_im_data;
  logic          busy;
  logic          done;

  int tests_run    = 0;
  int tests_failed = 0;

  twiddle_fetch_ctrl_if #(.DATA_W(DW)) tw_bus ();

  twiddle_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base        (base),
    .count       (count),
    .abort       (abort),
    .rom_addr    (rom_addr),
    .rom_re_data (rom_re_data),
    .rom_im_data (rom_im_data),
    .tw          (tw_bus),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] re_of(input logic [AW-1:0] a);
    return 16'h1100 + {11'd0, a};
  endfunction

  function automatic logic [DW-1:0] im_of(input logic [AW-1:0] a);
    return 16'h2200 + {10'd0, a, 1'b0} + {11'd0, a};
  endfunction

  // Registered-read ROM models: data for the address seen at an edge
  // appears right after that edge.
  always @(posedge clk) begin
    rom_re_data <= re_of(rom_addr);
    rom_im_data <= im_of(rom_addr);
  end

  // Advance to just after the next rising edge (the sampling/driving slot).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*DW+1:0] obs();
    return {tw_bus.tw_valid, tw_bus.tw_re, tw_bus.tw_im, tw_bus.tw_last};
  endfunction

  function automatic logic [2*DW+1:0] pair_exp(input logic [AW-1:0] a, input logic last);
    return {1'b1, re_of(a), im_of(a), last};
  endfunction

  task automatic test_reset();
    tests_run++;
    if (rom_addr !== '0) begin
      tests_failed++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr);
    end
    tests_run++;
    if ({tw_bus.tw_valid, tw_bus.tw_last, busy, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got valid/last/busy/done=%b expected 0000",
               {tw_bus.tw_valid, tw_bus.tw_last, busy, done});
    end
    tests_run++;
    if ({tw_bus.tw_re, tw_bus.tw_im} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h/%h expected 0/0", tw_bus.tw_re, tw_bus.tw_im);
    end
  endtask

  // base=5, count=4, always ready: pairs on cycles 3..6, done on cycle 7.
  task automatic test_basic();
    logic [2*DW+1:0] got, exp;
    logic [AW-1:0]   ea;
    start = 1'b1; base = 5'd5; count = 6'd4; tw_bus.tw_ready = 1'b1;
    step();                                   // cycle 1
    start = 1'b0;
    tests_run++;
    if (rom_addr !== 5'd5 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_cycle1: got addr=%h busy=%b expected addr=05 busy=1", rom_addr, busy);
    end
    step();                                   // cycle 2
    tests_run++;
    if (tw_bus.tw_valid !== 1'b0) begin
      tests_failed++; $display("FAIL basic_cycle2_valid: got %b expected 0", tw_bus.tw_valid);
    end
    for (int k = 0; k < 4; k++) begin         // cycles 3..6
      step();
      ea  = 5'd5 + AW'(k);
      got = obs();
      exp = pair_exp(ea, k == 3);
      tests_run++;
      if (got !== exp) begin
        tests_failed++; $display("FAIL basic_pair%0d: got %h expected %h", k, got, exp);
      end
      tests_run++;
      if (done !== 1'b0) begin
        tests_failed++; $display("FAIL basic_early_done%0d: got %b expected 0", k, done);
      end
    end
    step();                                   // cycle 7
    tests_run++;
    if ({done, busy, tw_bus.tw_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL basic_done: got done/busy/valid=%b expected 100", {done, busy, tw_bus.tw_valid});
    end
    step();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++; $display("FAIL basic_done_pulse: got %b expected 0", done);
    end
  endtask

  // base=30, count=4 wraps 30,31,0,1; a new start is issued in the done cycle.
  task automatic test_wrap_back_to_back();
    logic [2*DW+1:0] got, exp;
    logic [AW-1:0]   exp_addr [4];
    exp_addr[0] = 5'd30; exp_addr[1] = 5'd31; exp_addr[2] = 5'd0; exp_addr[3] = 5'd1;
    start = 1'b1; base = 5'd30; count = 6'd4; tw_bus.tw_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      got = obs();
      exp = pair_exp(exp_addr[k], k == 3);
      tests_run++;
      if (got !== exp) begin
        tests_failed++; $display("FAIL wrap_pair%0d: got %h expected %h", k, got, exp);
      end
    end
    step();                                   // done cycle: start again
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++; $display("FAIL wrap_done: got %b expected 1", done);
    end
    start = 1'b1; base = 5'd2; count = 6'd2;
    step();
    start = 1'b0;
    tests_run++;
    if (rom_addr !== 5'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept: got addr=%h busy=%b expected addr=02 busy=1", rom_addr, busy);
    end
    step();
    for (int k = 0; k < 2; k++) begin
      step();
      got = obs();
      exp = pair_exp(5'd2 + AW'(k), k == 1);
      tests_run++;
      if (got !== exp) begin
        tests_failed++; $display("FAIL b2b_pair%0d: got %h expected %h", k, got, exp);
      end
    end
    step();
    tests_run++;
    if ({done, busy} !== 2'b10) begin
      tests_failed++; $display("FAIL b2b_done: got done/busy=%b expected 10", {done, busy});
    end
  endtask

  // count=8 under random ready: in order, exactly once, stable while stalled,
  // at most 2 addresses ahead of delivery.
  task automatic test_backpressure();
    logic [AW-1:0]   b;
    logic [AW-1:0]   off;
    logic [2*DW+1:0] got, exp, held;
    logic            stall;
    logic            finished;
    int              k;
    b = 5'd12; k = 0; stall = 1'b0; finished = 1'b0; held = '0;
    start = 1'b1; base = b; count = 6'd8; tw_bus.tw_ready = 1'b0;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      got = obs();
      if (done) begin
        finished = 1'b1;
      end else begin
        if (stall) begin
          tests_run++;
          if (got !== held) begin
            tests_failed++; $display("FAIL bp_stable_c%0d: got %h expected %h", cyc, got, held);
          end
        end
        off = rom_addr - b;
        tests_run++;
        if (int'(off) - k > 2) begin
          tests_failed++;
          $display("FAIL bp_lead_c%0d: got %0d issued vs %0d delivered, expected lead <= 2",
                   cyc, off, k);
        end
        tw_bus.tw_ready = 1'($urandom_range(0, 1));
        if (tw_bus.tw_valid && tw_bus.tw_ready) begin
          exp = pair_exp(b + AW'(k), k == 7);
          tests_run++;
          if (got !== exp) begin
            tests_failed++; $display("FAIL bp_pair%0d: got %h expected %h", k, got, exp);
          end
          k++;
        end
        stall = tw_bus.tw_valid && !tw_bus.tw_ready;
        held  = got;
        step();
      end
    end
    tests_run++;
    if (!finished) begin
      tests_failed++; $display("FAIL bp_timeout: got no done expected done within 300 cycles");
    end
    tests_run++;
    if (k != 8) begin
      tests_failed++; $display("FAIL bp_count: got %0d pairs expected 8", k);
    end
    tw_bus.tw_ready = 1'b1;
  endtask

  task automatic test_count_zero();
    start = 1'b1; base = 5'd9; count = 6'd0;
    step();
    start = 1'b0;
    tests_run++;
    if ({done, busy, tw_bus.tw_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL zero_done: got done/busy/valid=%b expected 100", {done, busy, tw_bus.tw_valid});
    end
    step();
    tests_run++;
    if ({done, busy, tw_bus.tw_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL zero_after: got done/busy/valid=%b expected 000", {done, busy, tw_bus.tw_valid});
    end
  endtask

  // Fill the buffer with ready low, abort (with a competing start), then restart.
  task automatic test_abort();
    logic [2*DW+1:0] got, exp;
    start = 1'b1; base = 5'd20; count = 6'd8; tw_bus.tw_ready = 1'b0;
    step();
    start = 1'b0;
    repeat (3) step();                        // cycle 4: buffer holds 2 pairs
    got = obs();
    exp = pair_exp(5'd20, 1'b0);
    tests_run++;
    if (got !== exp || busy !== 1'b1) begin
      tests_failed++; $display("FAIL abort_full: got %h busy=%b expected %h busy=1", got, busy, exp);
    end
    abort = 1'b1; start = 1'b1; base = 5'd3; count = 6'd2;
    step();
    abort = 1'b0; start = 1'b0;
    tests_run++;
    if ({tw_bus.tw_valid, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL abort_flush: got valid/busy/done=%b expected 000", {tw_bus.tw_valid, busy, done});
    end
    step();
    tests_run++;
    if ({tw_bus.tw_valid, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL abort_quiet: got valid/busy/done=%b expected 000", {tw_bus.tw_valid, busy, done});
    end
    start = 1'b1; base = 5'd3; count = 6'd2; tw_bus.tw_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      step();
      got = obs();
      exp = pair_exp(5'd3 + AW'(k), k == 1);
      tests_run++;
      if (got !== exp) begin
        tests_failed++; $display("FAIL abort_restart%0d: got %h expected %h", k, got, exp);
      end
    end
    step();
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++; $display("FAIL abort_restart_done: got %b expected 1", done);
    end
  endtask

  // A start while busy must not disturb the running request.
  task automatic test_ignored_start();
    logic [2*DW+1:0] got, exp;
    start = 1'b1; base = 5'd10; count = 6'd3; tw_bus.tw_ready = 1'b1;
    step();
    start = 1'b0;
    step();                                   // cycle 2: competing start
    start = 1'b1; base = 5'd0; count = 6'd1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      got = obs();
      exp = pair_exp(5'd10 + AW'(k), k == 2);
      tests_run++;
      if (got !== exp || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL ignore_pair%0d: got %h busy=%b expected %h busy=1", k, got, busy, exp);
      end
    end
    step();
    tests_run++;
    if ({done, busy} !== 2'b10) begin
      tests_failed++; $display("FAIL ignore_done: got done/busy=%b expected 10", {done, busy});
    end
  endtask

  // Reset asserted between clock edges must clear outputs immediately.
  task automatic test_async_reset();
    start = 1'b1; base = 5'd7; count = 6'd6; tw_bus.tw_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();                        // cycle 4, mid-stream
    tests_run++;
    if (tw_bus.tw_valid !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre: got valid=%b busy=%b expected 1/1", tw_bus.tw_valid, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (rom_addr !== '0 || {tw_bus.tw_valid, tw_bus.tw_last, busy, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL areset_flags: got addr=%h valid/last/busy/done=%b expected 00 0000",
               rom_addr, {tw_bus.tw_valid, tw_bus.tw_last, busy, done});
    end
    tests_run++;
    if ({tw_bus.tw_re, tw_bus.tw_im} !== '0) begin
      tests_failed++;
      $display("FAIL areset_data: got %h/%h expected 0/0", tw_bus.tw_re, tw_bus.tw_im);
    end
    #1 rst_n = 1'b1;
    step();
    step();
    tests_run++;
    if ({tw_bus.tw_valid, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL areset_after: got valid/busy/done=%b expected 000", {tw_bus.tw_valid, busy, done});
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base = '0; count = '0; abort = 1'b0;
    tw_bus.tw_ready = 1'b0;
    repeat (2) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_basic();
    test_wrap_back_to_back();
    test_backpressure();
    test_count_zero();
    test_abort();
    test_ignored_start();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
